pipe_share_ctrl: RTL and testbench
==================================

Name: pipe_share_ctrl

Overview:
- Shares one 2-stage register pipeline (stage-1 -> stage-2 delay line) among NREQ requesters.
- Round-robin arbitration picks one requester per cycle.
- The pipeline uses valid/ready flow control with backpressure and a synchronous flush.
- Each output word carries the ID of the requester that produced it; the block sits between requesting units and a single downstream consumer.

Parameters:
- WIDTH, 64, data width of each requester word and of the output word.
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NREQ), width of the requester ID tag; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous pipeline clear.
- req_valid  input  NREQ  per-requester valid.
- req_data  input  NREQ*WIDTH  requester i's word is bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot or zero; word i is accepted at the edge where req_valid[i] & req_ready[i].
- out_valid  output  1  stage-2 holds a valid word.
- out_data  output  WIDTH  stage-2 data.
- out_id  output  IDW  requester index of the stage-2 word.
- out_ready  input  1  consumer accepts; transfer at the edge where out_valid & out_ready.

Behaviour:
- Reset (rst_n=0 at an edge):
  - s1_valid=0, s2_valid=0; out_valid=0, out_data=0, out_id=0.
  - Round-robin pointer = 0.
  - req_ready = 0 while rst_n=0.
  - Reset mid-operation discards all in-flight words; no partial transfer completes.
- Pipeline advance:
  - adv2 = !s2_valid | out_ready.
  - load1 = adv2 | !s1_valid.
  - On adv2, stage-2 takes stage-1 (data, id, valid).
  - On load1, stage-1 takes the granted word, or s1_valid=0 if nothing is granted.
  - Stage-2 holds data/id/valid stable while out_valid & !out_ready.
- Latency: a word accepted at edge k appears on out_* after edge k+1 when there is no stall; each stall cycle adds one.
- Throughput: one word per cycle with out_ready held high.
- Capacity: at most 2 words in flight.
- With out_ready=0:
  - Stage-2 fills, then stage-1 fills.
  - req_ready = 0 until a slot frees.
  - When out_ready returns to 1, the stage-1 word reaches out_* one cycle after the stage-2 word.
- Arbitration:
  - Combinational round-robin starting from the pointer, over requesters with req_valid=1.
  - req_ready[g] = load1 & !flush & rst_n for the granted g only.
  - On an accept, pointer <= (g+1) mod NREQ; otherwise the pointer holds.
  - No requester is starved: a continuously asserting requester is served within NREQ accepts.
- req_ready may depend combinationally on req_valid. A requester must not make req_valid depend on req_ready.
- Flush (at an edge):
  - s1_valid, s2_valid <= 0; out_valid falls the next cycle.
  - req_ready = 0 in the flush cycle, so nothing is accepted; the pointer holds.
  - An out_valid & out_ready transfer in the flush cycle still counts as delivered.
  - Data registers need not clear.
- Simultaneous events:
  - out_ready plus a new accept in the same cycle: both stages shift and stage-1 loads; no bubble.
  - Reset has priority over flush.
- Data is passed through unmodified; no width changes.

Decomposition:
- Package pipe_share_pkg:
  - function clog2_min1 (IDW, with a minimum of 1).
  - localparam defaults for WIDTH and NREQ.
  - typedef for the stage record {valid, id, data}.
- Sub-module rr_arb (NREQ): inputs req, ptr, en; outputs one-hot gnt and binary gnt_id. It is reused by later shared-resource controllers.
- Top level holds the pointer register, the two stage registers and the advance logic.

Test Plan (WIDTH=4, NREQ=4, 100 ns clock):
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=0, out_valid=0, out_data=0, out_id=0 throughout; after release the first grant goes to requester 0.
- Round-robin: all four valid with data 1, 3, 7, 5 and out_ready=1 -> out_id sequence 0, 1, 2, 3, 0 with matching data, one word per cycle; the first out_valid appears 2 edges after release.
- Latency: only requester 2 valid with data 'h7 for one cycle -> out_valid=1, out_data=7, out_id=2 exactly one cycle after acceptance, then out_valid=0.
- Backpressure: out_ready=0 with requesters 1 and 3 valid -> exactly 2 accepts, then req_ready=0; out_data held stable; after out_ready=1, words from requester 1 then 3 are delivered in consecutive cycles, none lost or duplicated.
- Flush: with 2 words in flight, pulse flush while req_valid[0]=1 -> no accept that cycle, out_valid=0 the next cycle, pointer unchanged; requester 0 is accepted the following cycle.
- Mid-operation reset: assert rst_n=0 during a stalled full pipe -> out_valid=0 at the next edge; after release the pointer restarts at 0.

Source files
------------

// File: rtl/pipe_share_pkg.sv
// Shared definitions for the pipelined shared-resource controllers.
package pipe_share_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NREQ_DEF  = 4;

  // Requester-ID width, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDW_DEF = clog2_min1(NREQ_DEF);

  // Stage record for the default configuration; parameterised users build the same shape locally.
  typedef struct packed {
    logic                 valid;
    logic [IDW_DEF-1:0]   id;
    logic [WIDTH_DEF-1:0] data;
  } stage_def_t;

endpackage

// File: rtl/pipe_share_ctrl_rr_arb.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arb
  import pipe_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic           found;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Wrap ptr+i back into 0..NREQ-1 without a divider.
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    if (found && en) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/pipe_share_ctrl.sv
// Two-stage valid/ready pipeline shared round-robin among NREQ requesters, with flush.
module pipe_share_ctrl
  import pipe_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  localparam int IDW  = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  typedef struct packed {
    logic             valid;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           s1_p1, s2_p2;
  logic [IDW-1:0]   ptr;
  logic             adv2, load1, arb_en, any_gnt;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] sel_data;

  assign adv2   = !s2_p2.valid || out_ready;
  assign load1  = adv2 || !s1_p1.valid;
  assign arb_en = load1 && !flush && rst_n;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign any_gnt   = |gnt;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_id == IDW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
  end

  // Stage 1 (accept) -> stage 2 (output); reset clears data too so out_* reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_p1 <= '0;
      s2_p2 <= '0;
      ptr   <= '0;
    end else if (flush) begin
      s1_p1.valid <= 1'b0;
      s2_p2.valid <= 1'b0;
    end else begin
      if (adv2) s2_p2 <= s1_p1;
      if (load1) begin
        s1_p1.valid <= any_gnt;
        s1_p1.id    <= gnt_id;
        s1_p1.data  <= sel_data;
      end
      if (any_gnt) ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  assign out_valid = s2_p2.valid;
  assign out_data  = s2_p2.data;
  assign out_id    = s2_p2.id;

endmodule

// File: tb/tb_pipe_share_ctrl.sv
// Scoreboard bench for pipe_share_ctrl with WIDTH=4, NREQ=4.
`timescale 1ns/1ps
module tb_pipe_share_ctrl;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        out_id;
  logic              out_ready;

  pipe_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [3:0] data);
    q.push_back({id, data});
  endtask

  // Monitor: every delivered word must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_word", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_id", 64'(out_id), 64'(e.id));
        check("out_data", 64'(out_data), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] rr_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rr_dat [5] = '{4'h1, 4'h3, 4'h7, 4'h5, 4'h1};

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'hF;
    req_data  = {4'h5, 4'h7, 4'h3, 4'h1};

    // Reset held for three edges with everyone requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_id", 64'(out_id), 64'(0));
    end

    // Round-robin, full throughput.
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      check("rr_req_ready", 64'(req_ready), 64'(rr_rdy[c]));
      push(rr_id[c], rr_dat[c]);
      tick();
      check("rr_out_valid", 64'(out_valid), (c >= 1) ? 64'(1) : 64'(0));
    end
    req_valid = '0;
    repeat (3) tick();

    // Single-word latency from requester 2 (pointer is 1 here).
    req_valid = 4'b0100;
    #2;
    check("lat_req_ready", 64'(req_ready), 64'(4'b0100));
    push(2'd2, 4'h7);
    tick();
    req_valid = '0;
    check("lat_early", 64'(out_valid), 64'(0));
    tick();
    check("lat_out_valid", 64'(out_valid), 64'(1));
    check("lat_out_data", 64'(out_data), 64'(7));
    check("lat_out_id", 64'(out_id), 64'(2));
    tick();
    check("lat_after", 64'(out_valid), 64'(0));

    // Requester 0 alone moves the pointer from 3 to 1.
    req_valid = 4'b0001;
    #2;
    check("wrap_req_ready", 64'(req_ready), 64'(4'b0001));
    push(2'd0, 4'h1);
    tick();
    req_valid = '0;
    repeat (2) tick();

    // Backpressure: two accepts fill the pipe, then nothing.
    out_ready = 1'b0;
    req_valid = 4'b1010;
    #2;
    check("bp_rdy1", 64'(req_ready), 64'(4'b0010));
    push(2'd1, 4'h3);
    tick();
    #2;
    check("bp_rdy3", 64'(req_ready), 64'(4'b1000));
    push(2'd3, 4'h5);
    tick();
    #2;
    check("bp_full_rdy", 64'(req_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_out_data", 64'(out_data), 64'(3));
    check("bp_out_id", 64'(out_id), 64'(1));
    tick();
    #2;
    check("bp_hold_rdy", 64'(req_ready), 64'(0));
    check("bp_hold_data", 64'(out_data), 64'(3));
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    check("bp_second_valid", 64'(out_valid), 64'(1));
    check("bp_second_id", 64'(out_id), 64'(3));
    tick();
    check("bp_drained", 64'(out_valid), 64'(0));

    // Flush with two words in flight (pointer 0 -> 2 after the fills).
    out_ready = 1'b0;
    req_valid = 4'b0011;
    #2;
    check("fl_fill0", 64'(req_ready), 64'(4'b0001));
    tick();
    #2;
    check("fl_fill1", 64'(req_ready), 64'(4'b0010));
    tick();
    flush = 1'b1;
    req_valid = 4'b0001;
    #2;
    check("fl_no_accept", 64'(req_ready), 64'(0));
    tick();
    flush = 1'b0;
    #2;
    check("fl_out_valid", 64'(out_valid), 64'(0));
    req_valid = 4'b0111;
    #2;
    check("fl_ptr_held", 64'(req_ready), 64'(4'b0100));
    req_valid = 4'b0001;
    #2;
    check("fl_req0_rdy", 64'(req_ready), 64'(4'b0001));
    push(2'd0, 4'h1);
    out_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    check("fl_req0_out", 64'(out_valid), 64'(1));
    check("fl_req0_id", 64'(out_id), 64'(0));
    tick();

    // Reset during a stalled full pipe (pointer 1 -> grants 1, 2).
    out_ready = 1'b0;
    req_valid = 4'hF;
    repeat (2) tick();
    #2;
    check("mr_full_rdy", 64'(req_ready), 64'(0));
    check("mr_full_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #2;
    check("mr_rdy_in_rst", 64'(req_ready), 64'(0));
    tick();
    check("mr_out_valid", 64'(out_valid), 64'(0));
    check("mr_out_data", 64'(out_data), 64'(0));
    check("mr_out_id", 64'(out_id), 64'(0));
    rst_n = 1'b1;
    #2;
    check("mr_ptr_zero", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    out_ready = 1'b1;
    repeat (3) tick();

    check("queue_empty", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
